// File: rtl/execute_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_pipe_if
// Brief    : Upstream/downstream handshake bundle for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_ctrl;
    logic [XLEN-1:0]  in_rd1;
    logic [XLEN-1:0]  in_rd2;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic             in_branch;
    logic [2:0]       in_funct3;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_taken;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_alu_ctrl, in_rd1, in_rd2, in_pc, in_imm,
               in_branch, in_funct3, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_next_pc, out_taken,
               out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_alu_ctrl, in_rd1, in_rd2, in_pc, in_imm,
               in_branch, in_funct3, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_next_pc, out_taken,
               out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : execute_pipe
// Brief    : Registered ALU/branch execute stage with iterative MUL and flush.
// Revision : 1.0 - initial release
// ============================================================================
module execute_pipe #(
    parameter int XLEN   = 64,
    parameter int TAG_W  = 5,
    parameter int MUL_EN = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    execute_pipe_if.slave    pipe_if
);
    localparam int         c_SH_W   = $clog2(XLEN);
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_SRA = 4'b1000;
    localparam logic [3:0] c_OP_SLTU= 4'b1001;
    localparam logic [3:0] c_OP_MUL = 4'b1010;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XLEN-1:0]   w_a, w_b, w_alu, w_next_pc, w_mul_final, w_mul_addend;
    logic [c_SH_W-1:0] w_shamt;
    logic              w_lt_s, w_lt_u, w_eq, w_cond, w_taken;
    logic              w_out_free, w_in_ready, w_accept, w_is_mul;
    logic              w_mul_last, w_mul_retire;

    logic              r_out_valid, r_out_taken;
    logic [XLEN-1:0]   r_out_result, r_out_next_pc;
    logic [TAG_W-1:0]  r_out_tag;

    logic [XLEN-1:0]   r_mcand, r_mplier, r_acc, r_m_next_pc;
    logic [c_SH_W-1:0] r_cnt;
    logic              r_mul_done, r_m_taken;
    logic [TAG_W-1:0]  r_m_tag;

    assign w_a     = pipe_if.in_rd1;
    assign w_b     = pipe_if.in_rd2;
    assign w_shamt = w_b[c_SH_W-1:0];
    assign w_lt_s  = $signed(w_a) < $signed(w_b);
    assign w_lt_u  = w_a < w_b;
    assign w_eq    = w_a == w_b;

    always_comb begin
        w_alu = '0;
        case (pipe_if.in_alu_ctrl)
            c_OP_AND:  w_alu = w_a & w_b;
            c_OP_OR:   w_alu = w_a | w_b;
            c_OP_ADD:  w_alu = w_a + w_b;
            c_OP_SLL:  w_alu = w_a << w_shamt;
            c_OP_XOR:  w_alu = w_a ^ w_b;
            c_OP_SRL:  w_alu = w_a >> w_shamt;
            c_OP_SUB:  w_alu = w_a - w_b;
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
            c_OP_SRA:  w_alu = $signed(w_a) >>> w_shamt;
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (pipe_if.in_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken   = pipe_if.in_branch && w_cond;
    assign w_next_pc = w_taken ? pipe_if.in_pc + (pipe_if.in_imm << 1)
                               : pipe_if.in_pc + XLEN'(4);

    assign w_out_free = !r_out_valid || pipe_if.out_ready;
    assign w_in_ready = (r_state == S_IDLE) && w_out_free && !pipe_if.flush;
    assign w_accept   = pipe_if.in_valid && w_in_ready;
    assign w_is_mul   = (MUL_EN != 0) && (pipe_if.in_alu_ctrl == c_OP_MUL);

    // A finished product waits in r_acc (r_mul_done) if the output is still occupied.
    assign w_mul_addend = r_mplier[0] ? r_mcand : '0;
    assign w_mul_final  = r_mul_done ? r_acc : r_acc + w_mul_addend;
    assign w_mul_last   = (r_state == S_MUL) && (r_mul_done || (r_cnt == '0));
    assign w_mul_retire = w_mul_last && w_out_free;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_retire)         w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (pipe_if.flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_next_pc <= '0;
            r_out_taken   <= 1'b0;
            r_out_tag     <= '0;
        end else if (pipe_if.flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_alu;
            r_out_next_pc <= w_next_pc;
            r_out_taken   <= w_taken;
            r_out_tag     <= pipe_if.in_tag;
        end else if (w_mul_retire) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_mul_final;
            r_out_next_pc <= r_m_next_pc;
            r_out_taken   <= r_m_taken;
            r_out_tag     <= r_m_tag;
        end else if (pipe_if.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mul_done  <= 1'b0;
            r_m_next_pc <= '0;
            r_m_taken   <= 1'b0;
            r_m_tag     <= '0;
        end else if (pipe_if.flush) begin
            r_mul_done  <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mcand     <= w_a;
            r_mplier    <= w_b;
            r_acc       <= '0;
            r_cnt       <= c_SH_W'(XLEN-1);
            r_mul_done  <= 1'b0;
            r_m_next_pc <= w_next_pc;
            r_m_taken   <= w_taken;
            r_m_tag     <= pipe_if.in_tag;
        end else if (r_state == S_MUL) begin
            if (w_mul_last) begin
                r_acc      <= w_mul_final;
                r_mul_done <= !w_out_free;
            end else begin
                r_acc    <= r_acc + w_mul_addend;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end
        end
    end

    assign pipe_if.in_ready    = w_in_ready;
    assign pipe_if.out_valid   = r_out_valid;
    assign pipe_if.out_result  = r_out_result;
    assign pipe_if.out_next_pc = r_out_next_pc;
    assign pipe_if.out_taken   = r_out_taken;
    assign pipe_if.out_tag     = r_out_tag;
    assign pipe_if.busy        = (r_state == S_MUL);
endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_pipe
// Brief    : Directed and randomized self-checking bench for execute_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_pipe;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    execute_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_EN(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .pipe_if (bus)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] npc;
        logic        tk;
        logic [4:0]  tag;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int                 sh = int'(b[5:0]);
        logic signed [63:0] sa = a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a << sh;
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd8:    return sa >>> sh;
            4'd9:    return (a < b) ? 64'd1 : 64'd0;
            4'd10:   return a * b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic exp_t ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] pc, input logic [63:0] imm, input logic br,
                                    input logic [2:0] f3, input logic [4:0] tag);
        exp_t e;
        logic c;
        case (f3)
            3'd0:    c = (a == b);
            3'd1:    c = (a != b);
            3'd4:    c = ($signed(a) < $signed(b));
            3'd5:    c = ($signed(a) >= $signed(b));
            3'd6:    c = (a < b);
            3'd7:    c = (a >= b);
            default: c = 1'b0;
        endcase
        e.res = ref_alu(op, a, b);
        e.tk  = br && c;
        e.npc = e.tk ? pc + 2 * imm : pc + 64'd4;
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pc, input logic [63:0] imm, input logic br,
                         input logic [2:0] f3, input logic [4:0] tag);
        bus.in_valid    = 1'b1;
        bus.in_alu_ctrl = op;
        bus.in_rd1      = a;
        bus.in_rd2      = b;
        bus.in_pc       = pc;
        bus.in_imm      = imm;
        bus.in_branch   = br;
        bus.in_funct3   = f3;
        bus.in_tag      = tag;
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b, pc, imm;
        logic        br;
        logic [2:0]  f3;
        logic [4:0]  tg;
        int          seen;
        exp_t        e;

        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 3'd0, 5'd0);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid",  64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.out_result, 64'd0);
        chk("rst_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_npc",    bus.out_next_pc, 64'd0);

        // back-to-back ADD then SRA
        drive(4'd2, 64'd5, 64'd7, 64'h0, 64'h0, 1'b0, 3'd0, 5'd1);
        tick();
        chk("add_valid",  64'(bus.out_valid), 64'd1);
        chk("add_result", bus.out_result, 64'd12);
        chk("add_tag",    64'(bus.out_tag), 64'd1);
        drive(4'd8, 64'hFFFF_FFFF_FFFF_FF00, 64'd4, 64'h0, 64'h0, 1'b0, 3'd0, 5'd2);
        tick();
        chk("sra_valid",  64'(bus.out_valid), 64'd1);
        chk("sra_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFF0);
        bus.in_valid = 1'b0;
        tick();
        chk("idle_valid", 64'(bus.out_valid), 64'd0);

        // BLT vs BLTU on -1 / 1
        drive(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'd8, 1'b1, 3'b100, 5'd3);
        tick();
        chk("blt_taken",  64'(bus.out_taken), 64'd1);
        chk("blt_npc",    bus.out_next_pc, 64'h110);
        chk("blt_result", bus.out_result, 64'd0);
        drive(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'd8, 1'b1, 3'b110, 5'd3);
        tick();
        chk("bltu_taken", 64'(bus.out_taken), 64'd0);
        chk("bltu_npc",   bus.out_next_pc, 64'h104);
        bus.in_valid = 1'b0;
        tick();

        // 64-cycle MUL
        drive(4'd10, 64'h1_0000_0003, 64'h1_0000_0005, 64'h200, 64'h0, 1'b0, 3'd0, 5'd7);
        #1;
        chk("mul_in_ready_pre", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("mul_busy0",  64'(bus.busy), 64'd1);
        chk("mul_ready0", 64'(bus.in_ready), 64'd0);
        for (int k = 1; k < 64; k++) begin
            tick();
            chk("mul_busy",  64'(bus.busy), 64'd1);
            chk("mul_ready", 64'(bus.in_ready), 64'd0);
            chk("mul_valid", 64'(bus.out_valid), 64'd0);
        end
        tick();
        chk("mul_done_valid", 64'(bus.out_valid), 64'd1);
        chk("mul_done_busy",  64'(bus.busy), 64'd0);
        chk("mul_result",     bus.out_result, 64'h0000_0008_0000_000F);
        chk("mul_tag",        64'(bus.out_tag), 64'd7);
        chk("mul_npc",        bus.out_next_pc, 64'h204);
        tick();

        // downstream stall with a pending op held upstream
        bus.out_ready = 1'b0;
        drive(4'd4, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0, 1'b0, 3'd0, 5'd4);
        tick();
        chk("stall_first", bus.out_result, 64'hFF00);
        drive(4'd1, 64'h1200, 64'h0034, 64'h0, 64'h0, 1'b0, 3'd0, 5'd5);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            chk("stall_valid",  64'(bus.out_valid), 64'd1);
            chk("stall_result", bus.out_result, 64'hFF00);
            chk("stall_tag",    64'(bus.out_tag), 64'd4);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("unstall_result", bus.out_result, 64'h1234);
        chk("unstall_tag",    64'(bus.out_tag), 64'd5);
        bus.in_valid = 1'b0;
        tick();

        // flush ten cycles into a MUL
        drive(4'd10, 64'd7, 64'd9, 64'h0, 64'h0, 1'b0, 3'd0, 5'd6);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready_hi", 64'(bus.in_ready), 64'd0);
        tick();
        chk("flush_busy",  64'(bus.busy), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        bus.flush = 1'b0;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("flush_no_product", 64'(seen), 64'd0);

        // reset in the middle of a MUL
        drive(4'd10, 64'd11, 64'd13, 64'h0, 64'h0, 1'b0, 3'd0, 5'd8);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmul_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (70) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("rstmul_no_product", 64'(seen), 64'd0);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd2;
            a   = {$urandom(), $urandom()};
            b   = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
            pc  = {$urandom(), $urandom()};
            imm = {$urandom(), $urandom()};
            br  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            tg  = 5'($urandom_range(0, 31));
            drive(op, a, b, pc, imm, br, f3, tg);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_result", bus.out_result, e.res);
                    chk("rnd_npc",    bus.out_next_pc, e.npc);
                    chk("rnd_taken",  64'(bus.out_taken), 64'(e.tk));
                    chk("rnd_tag",    64'(bus.out_tag), 64'(e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(ref_op(op, a, b, pc, imm, br, f3, tg));
            tick();
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 200 && (sb.size() != 0 || bus.busy || bus.out_valid); k++) begin
            #1;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("drain_unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("drain_result", bus.out_result, e.res);
                    chk("drain_tag",    64'(bus.out_tag), 64'(e.tag));
                end
            end
            tick();
        end
        chk("drain_left", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Next-generation execute stage for the pipelined core. Register-outputs ALU and branch results into the EX/MEM boundary behind a valid/ready handshake.
- Over the single-cycle execute stage it adds:
  - parametrised XLEN;
  - the full RV branch-condition set;
  - signed and unsigned compares, XOR, SRL and SRA;
  - an optional iterative multiplier (MUL, low half);
  - pipeline flush.
- Sits between decode/register-read and memory stage.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the opaque tag passed alongside each op (destination register index).
- MUL_EN, 1, 1 = iterative MUL implemented; 0 = MUL code returns 0 with 1-cycle latency.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  kill in-flight and output-held op
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept op this cycle
- in_alu_ctrl  in  4  op code (below)
- in_rd1  in  XLEN  operand a
- in_rd2  in  XLEN  operand b
- in_pc  in  XLEN  PC of op
- in_imm  in  XLEN  sign-extended immediate
- in_branch  in  1  op is conditional branch
- in_funct3  in  3  branch condition
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  ALU result
- out_next_pc  out  XLEN  resolved next PC
- out_taken  out  1  branch taken
- out_tag  out  TAG_W  tag of result
- busy  out  1  multiplier iterating

Behaviour:
- Reset: all outputs are 0, state is IDLE, and in_ready is 1. Reset mid-MUL aborts the op with no output.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB.
  - 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MUL.
  - Any other code yields result 0.
- Shift amount is rd2[log2(XLEN)-1:0]. SLT and SLTU results are 0 or 1, zero-extended.
- Arithmetic is modulo 2^XLEN with no overflow flag.
- Branch condition, evaluated on rd1/rd2 only when in_branch=1:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 mean not taken.
- Branch targets:
  - Taken: next_pc = pc + (imm << 1), low XLEN bits.
  - Otherwise: next_pc = pc + 4.
  - For branches, out_result carries the selected ALU code's result unchanged.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - Accept occurs when in_valid && in_ready.
  - The output register holds stable while out_valid && !out_ready.
- Latency for non-MUL ops: accepted on edge E, out_* valid after E. Back-to-back throughput is 1/cycle while out_ready=1.
- MUL path, MUL_EN=1 (states IDLE -> MUL -> IDLE):
  - On accept, latch multiplicand, multiplier, pc, imm, branch, funct3 and tag.
  - Counter is loaded with XLEN-1 and busy=1.
  - Each cycle performs one shift-add step on multiplier LSB.
  - When counter=0, the final step writes the low XLEN product bits to out_result. That edge is accept edge + XLEN, at which out_valid=1, state=IDLE and busy=0.
  - in_ready=0 for the whole MUL state.
  - Downstream stall cannot occur on MUL entry, because acceptance requires the output to be free.
  - If out_valid is still held when MUL finishes, the MUL state extends until out_ready. The multiplier result is held internally, never overwriting.
- Flush has priority over everything except reset. Next edge: out_valid=0, state=IDLE, busy=0, and no op is accepted that cycle. The other out_* keep their last values (don't-care).
- Simultaneous out_ready and accept: the old result is consumed and the new one is registered on the same edge.
- MUL_EN=0: code 1010 behaves as a single-cycle op with result 0, and busy stays 0.

Test Plan:
- Reset then idle -> out_valid=0, out_result=0, in_ready=1, busy=0 on the first post-reset cycle.
- ADD rd1=5, rd2=7, then SRA rd1=0xFFFF_FFFF_FFFF_FF00, rd2=4, back-to-back with out_ready=1 -> results 12, then 0xFFFF_FFFF_FFFF_FFF0 on consecutive cycles, 1 cycle after each accept.
- BLT rd1=-1, rd2=1, pc=0x100, imm=8 -> out_taken=1, out_next_pc=0x110. The same op as BLTU -> out_taken=0, out_next_pc=0x104.
- MUL rd1=0x1_0000_0003, rd2=0x1_0000_0005 (XLEN=64) -> busy=1 for 64 cycles, in_ready=0. out_valid rises exactly 64 cycles after accept with out_result=0x0000_0008_0000_000F.
- out_ready=0 while out_valid=1 with in_valid held -> in_ready=0 and outputs stable for 5 cycles. out_ready=1 -> pending op accepted on the same edge.
- Flush asserted 10 cycles into a MUL -> next cycle busy=0, out_valid=0, in_ready=1. The aborted product never appears on the output.
